// File: rtl/uart_rx_if.sv
// Host-side status/acknowledge bundle for the 8N1 UART receiver.
// The receiver drives the byte and flags; the host returns the acknowledge.
`timescale 1ns/1ps

interface uart_rx_if;
   logic [7:0] data;
   logic       rdy;
   logic       ferr;
   logic       overrun;
   logic       rdy_clr;

   modport master (input data, rdy, ferr, overrun, output rdy_clr);
   modport slave  (output data, rdy, ferr, overrun, input rdy_clr);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample strobe: synchronises rx,
// qualifies the start bit, samples mid-bit and reports byte/ferr/overrun.
`timescale 1ns/1ps

module uart_rx (
   input  logic     clk_50m,
   input  logic     rst,
   input  logic     rxclk_en,
   input  logic     rx,
   uart_rx_if.slave host
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t     state_r;
   logic       rx_meta_r;
   logic       rx_sync_r;
   logic [3:0] sample_r;
   logic [2:0] bitpos_r;
   logic [7:0] scratch_r;
   logic [7:0] data_r;
   logic       rdy_r;
   logic       ferr_r;
   logic       overrun_r;

   assign host.data    = data_r;
   assign host.rdy     = rdy_r;
   assign host.ferr    = ferr_r;
   assign host.overrun = overrun_r;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Receive FSM and host status; tick events are written after the clear so a coinciding set wins.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         sample_r  <= 4'd0;
         bitpos_r  <= 3'd0;
         scratch_r <= 8'h00;
         data_r    <= 8'h00;
         rdy_r     <= 1'b0;
         ferr_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (host.rdy_clr) begin
            rdy_r     <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
         end
         if (rxclk_en) begin
            case (state_r)
               ST_IDLE: begin
                  if (!rx_sync_r) begin
                     state_r  <= ST_START;
                     sample_r <= 4'd1;
                  end
               end
               ST_START: begin
                  if (rx_sync_r) begin
                     state_r  <= ST_IDLE;
                     sample_r <= 4'd0;
                  end else if (sample_r == 4'd7) begin
                     state_r  <= ST_DATA;
                     sample_r <= 4'd0;
                     bitpos_r <= 3'd0;
                  end else begin
                     sample_r <= sample_r + 4'd1;
                  end
               end
               ST_DATA: begin
                  if (sample_r == 4'd15) begin
                     scratch_r[bitpos_r] <= rx_sync_r;
                     sample_r            <= 4'd0;
                     if (bitpos_r == 3'd7) begin
                        state_r <= ST_STOP;
                     end else begin
                        bitpos_r <= bitpos_r + 3'd1;
                     end
                  end else begin
                     sample_r <= sample_r + 4'd1;
                  end
               end
               ST_STOP: begin
                  if (sample_r == 4'd15) begin
                     if (rx_sync_r) begin
                        data_r <= scratch_r;
                        rdy_r  <= 1'b1;
                        // An acknowledge on this cycle consumes the old byte, so no overrun.
                        if (rdy_r && !host.rdy_clr) begin
                           overrun_r <= 1'b1;
                        end
                     end else begin
                        ferr_r <= 1'b1;
                     end
                     state_r  <= ST_IDLE;
                     sample_r <= 4'd0;
                  end else begin
                     sample_r <= sample_r + 4'd1;
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  sample_r <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver sitting directly downstream of the baud rate generator: it consumes the 16x oversample strobe `rxclk_en` and recovers bytes from the serial `rx` line. It synchronises the line, qualifies the start bit, and samples each bit at mid-bit. Each received byte is presented on a holding register with a ready flag, framing-error status and overrun status for the host logic.

## Interface
Parameters:
- None. The frame format is fixed at 1 start bit, 8 data bits sent LSB first, no parity and 1 stop bit. Oversampling is fixed at 16 ticks per bit.

Ports:
- `clk_50m`  in  1  system clock; every flop in the block is clocked on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `rxclk_en`  in  1  single-cycle 16x oversample strobe from the baud generator
- `rx`  in  1  asynchronous serial input; idles high
- `rdy_clr`  in  1  host acknowledge; clears `rdy`, `ferr` and `overrun`
- `data`  out  8  last correctly framed byte
- `rdy`  out  1  a new byte is valid in `data`
- `ferr`  out  1  framing error: the stop bit was sampled low
- `overrun`  out  1  a byte completed while `rdy` was still set

## Operation
- **Synchroniser:** `rx` passes through 2 flops, giving `rx_s`. Both flops reset to 1. All decisions use `rx_s`.
- **Tick gating:** state, the `sample` counter (4 bits), the `bitpos` counter (3 bits) and the shift register `scratch` (8 bits) change only on cycles where `rxclk_en`=1. `rdy_clr` and `rst` act on any cycle.
- **IDLE:**
  - On a tick with `rx_s`=0: go to START and set `sample`=1.
  - Otherwise stay in IDLE.
- **START:** on each tick:
  - If `rx_s`=1, the start bit was a glitch: go to IDLE and set `sample`=0.
  - Else if `sample`=7 (8 consecutive low ticks, i.e. mid-start-bit): go to DATA and set `sample`=0, `bitpos`=0.
  - Else increment `sample`.
- **DATA:** on each tick:
  - If `sample`=15: set `scratch[bitpos]`=`rx_s` and `sample`=0. If `bitpos`=7 go to STOP, else increment `bitpos`.
  - Else increment `sample`.
- **STOP:** on each tick:
  - If `sample`=15 and `rx_s`=1: load `data`=`scratch` and set `rdy`=1. If `rdy` was already 1 and `rdy_clr` is not asserted this cycle, also set `overrun`=1.
  - If `sample`=15 and `rx_s`=0: set `ferr`=1. `data`, `rdy` and `overrun` are unchanged.
  - In both cases at `sample`=15, go to IDLE with `sample`=0. Otherwise increment `sample`.
- **Stop-bit handling:** the remaining half of the stop bit is absorbed in IDLE, because the line is high.
- **`rdy_clr`:** clears `rdy`, `ferr` and `overrun`. If it coincides with a completion or error event, the set wins:
  - Completion: `rdy`=1, `data` is updated, and `overrun` stays 0.
  - Framing error: `ferr`=1.
- **Reset:**
  - State returns to IDLE and `sample`, `bitpos`, `scratch` and `data` go to 0.
  - `rdy`, `ferr` and `overrun` go to 0.
  - This applies mid-frame as well: a partial frame is discarded with no flag.
- **Counter wrap:** `sample` and `bitpos` are reloaded explicitly and never wrap implicitly.

## Timing
- **Reset values:** `data`=8'h00, `rdy`=0, `ferr`=0, `overrun`=0.
- **Input latency:** a pin edge is visible on `rx_s` 2 clocks later.
- **Start detection:** requires 8 low ticks, so the first data sample falls 8+16 = 24 ticks after the start tick.
- **Bit spacing:** each subsequent data sample follows 16 ticks after the previous one. The stop sample falls 16 ticks after bit 7.
- **Frame latency:** `rdy` rises on the clock after the stop-sample tick, which is 152 ticks after the first low tick.
- **Output behaviour:** `data` and `rdy` change on the same edge. `data` is stable until the next good frame or reset.
- **Clock rate:** at 50 MHz the strobe comes every 28 clocks, so a nominal frame is about 4256 clocks to `rdy`.
- **Back-to-back frames:** a new start bit may begin immediately after the stop bit. Capture of frame N+1 overlaps `rdy` from frame N.

## Test plan
- **Good byte:** send 0xA5 with exact 16-tick bits → `data`=8'hA5, `rdy`=1, `ferr`=0, `overrun`=0. Then `rdy_clr` pulse → `rdy`=0 next clock.
- **Start glitch:** `rx` low for 4 ticks, then high → block returns to IDLE; `rdy` stays 0 and no byte is produced. A following 0x3C frame receives correctly.
- **Framing error:** preload `data`=8'h11 via a good frame, clear it, then send 0x7E with the stop bit low → `ferr`=1, `rdy`=0, `data`=8'h11. The next good 0x55 frame → `rdy`=1, `data`=8'h55.
- **Overrun:** two back-to-back frames 0x01 then 0xFE with no `rdy_clr` → `data`=8'hFE, `rdy`=1, `overrun`=1. `rdy_clr` → all three flags 0.
- **Simultaneous clear:** assert `rdy_clr` on exactly the cycle the second frame completes → `rdy`=1, `overrun`=0, `data` = the second byte.
- **Reset mid-frame:** assert `rst` during bit 4 of 0xC3 → all outputs 0 on the next clock and the block is in IDLE. A subsequent 0x9A frame receives correctly.
